// File: rtl/if_pkg.sv
// Shared types for the instruction-fetch queue: FSM states, queue entry layout
// and the sequential PC increment.
package if_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

    localparam int IF_XLEN = 32;
    localparam int PC_INC  = 4;

    typedef struct packed {
        logic [IF_XLEN-1:0] pc;
        logic [IF_XLEN-1:0] ir;
    } if_entry_t;

endpackage

// File: rtl/if_fifo.sv
// Circular buffer of fetched instructions; head/tail wrap at QDEPTH (power of two).
// Flush empties the buffer on the next clock edge.
module if_fifo
    import if_pkg::*;
#(
    parameter int  QDEPTH  = 4,
    parameter type entry_t = if_entry_t,
    localparam int PW      = $clog2(QDEPTH),
    localparam int CW      = $clog2(QDEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          enq,
    input  entry_t        enq_data,
    input  logic          deq,
    output entry_t        head_entry,
    output logic [CW-1:0] count
);

    entry_t        mem [QDEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic          do_enq;
    logic          do_deq;

    assign do_enq     = enq && (count != CW'(QDEPTH));
    assign do_deq     = deq && (count != '0);
    assign head_entry = mem[head];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_enq) tail <= tail + PW'(1);
            if (do_deq) head <= head + PW'(1);
            case ({do_enq, do_deq})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (do_enq && !flush) mem[tail] <= enq_data;
    end

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch unit: one outstanding imem request, QDEPTH-entry instruction queue,
// redirect flush with stale-response drain. Optional IF_BYPASS_EN adds a memory-to-decode bypass.
module if_fetch_queue
    import if_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              QDEPTH   = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    input  logic            deq_ready,
    output logic            out_valid,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_npc,
    output logic [XLEN-1:0] out_ir
);

    localparam int              CW  = $clog2(QDEPTH) + 1;
    localparam logic [XLEN-1:0] INC = XLEN'(PC_INC);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] ir;
    } entry_t;

    fetch_state_t    state;
    fetch_state_t    state_n;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] fetch_pc_n;
    logic [CW-1:0]   count;
    entry_t          head_entry;
    entry_t          enq_entry;
    logic            req_fire;
    logic            resp_take;
    logic            byp_hit;
    logic            enq;
    logic            deq;

    assign imem_addr      = {fetch_pc[XLEN-1:2], 2'b00};
    assign imem_req_valid = (state == FETCH) && (count < CW'(QDEPTH));
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign resp_take      = (state == WAIT) && imem_resp_valid && !redirect_valid;

`ifdef IF_BYPASS_EN
    assign byp_hit = resp_take && (count == '0);
`else
    assign byp_hit = 1'b0;
`endif

    // A bypassed instruction that decode accepts never occupies a queue slot.
    assign enq       = resp_take && !(byp_hit && deq_ready);
    assign deq       = (count != '0) && deq_ready && !redirect_valid;
    assign enq_entry = '{pc: fetch_pc, ir: imem_resp_data};

    if_fifo #(
        .QDEPTH  (QDEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect_valid),
        .enq        (enq),
        .enq_data   (enq_entry),
        .deq        (deq),
        .head_entry (head_entry),
        .count      (count)
    );

    assign out_valid = (count != '0) || byp_hit;
    assign out_npc   = out_valid ? out_pc + INC : '0;

    always_comb begin
        out_pc = '0;
        out_ir = '0;
        if (byp_hit) begin
            out_pc = fetch_pc;
            out_ir = imem_resp_data;
        end else if (count != '0) begin
            out_pc = head_entry.pc;
            out_ir = head_entry.ir;
        end
    end

    always_comb begin
        state_n    = state;
        fetch_pc_n = fetch_pc;
        case (state)
            IDLE:    state_n = FETCH;
            FETCH:   if (req_fire) state_n = WAIT;
            WAIT: begin
                if (imem_resp_valid) begin
                    state_n    = FETCH;
                    fetch_pc_n = fetch_pc + INC;
                end
            end
            DRAIN:   if (imem_resp_valid) state_n = FETCH;
            default: state_n = IDLE;
        endcase
        // Redirect wins; anything in flight at this point belongs to the old path.
        if (redirect_valid) begin
            fetch_pc_n = {redirect_pc[XLEN-1:2], 2'b00};
            if (state == WAIT || state == DRAIN) begin
                state_n = imem_resp_valid ? FETCH : DRAIN;
            end else begin
                state_n = req_fire ? DRAIN : FETCH;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
        end else begin
            state    <= state_n;
            fetch_pc <= fetch_pc_n;
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Self-checking bench for if_fetch_queue: directed scenarios plus a randomized run
// against a transaction-level model (expected fetch address, instruction queue, stale flag).
module tb_if_fetch_queue;

    localparam int          XLEN     = 32;
    localparam int          QDEPTH   = 4;
    localparam logic [31:0] RESET_PC = 32'h100;
`ifdef IF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        deq_ready;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_npc;
    logic [31:0] out_ir;

    int n_checks = 0;
    int n_fail   = 0;

    bit          mem_pending;
    logic [31:0] mem_addr;
    int          mem_cnt;
    int          mem_lat = 1;

    logic        s_fire, s_resp, s_req_valid, s_out_valid, s_redirect, s_deq_ready;
    logic [31:0] s_addr, s_out_pc, s_out_npc, s_out_ir, s_rpc;

    if_fetch_queue #(
        .XLEN     (XLEN),
        .QDEPTH   (QDEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .deq_ready       (deq_ready),
        .out_valid       (out_valid),
        .out_pc          (out_pc),
        .out_npc         (out_npc),
        .out_ir          (out_ir)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_func(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // One clock cycle: memory drives its response, outputs are sampled, edge passes.
    task automatic tick();
        if (mem_pending && mem_cnt == 0) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_func(mem_addr);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = $urandom;
        end
        #1;
        s_fire      = imem_req_valid && imem_req_ready;
        s_addr      = imem_addr;
        s_resp      = imem_resp_valid;
        s_req_valid = imem_req_valid;
        s_out_valid = out_valid;
        s_out_pc    = out_pc;
        s_out_npc   = out_npc;
        s_out_ir    = out_ir;
        s_redirect  = redirect_valid;
        s_rpc       = redirect_pc;
        s_deq_ready = deq_ready;
        @(posedge clk);
        if (s_resp) mem_pending = 1'b0;
        else if (mem_pending) mem_cnt--;
        if (s_fire) begin
            mem_pending = 1'b1;
            mem_addr    = s_addr;
            mem_cnt     = mem_lat - 1;
        end
        @(negedge clk);
        imem_resp_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst             = 1'b1;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        imem_req_ready  = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        deq_ready       = 1'b1;
        mem_pending     = 1'b0;
        mem_lat         = 1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst             = 1'b1;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        imem_req_ready  = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        deq_ready       = 1'b1;
        mem_pending     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valids: out_valid=%b req_valid=%b expected 0/0", out_valid, imem_req_valid);
        end
        n_checks++;
        if (out_pc !== 32'h0 || out_npc !== 32'h0 || out_ir !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: pc=%h npc=%h ir=%h expected all 0", out_pc, out_npc, out_ir);
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if (s_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_no_req: req_valid=%b expected 0", s_req_valid);
        end
        tick();
        n_checks++;
        if (s_req_valid !== 1'b1 || s_addr !== RESET_PC) begin
            n_fail++;
            $display("FAIL first_req: req_valid=%b addr=%h expected 1/%h", s_req_valid, s_addr, RESET_PC);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_addr, exp_pc;
        int nreq, nout;
        do_reset();
        exp_addr = RESET_PC;
        exp_pc   = RESET_PC;
        nreq     = 0;
        nout     = 0;
        for (int c = 0; c < 40 && (nreq < 3 || nout < 3); c++) begin
            tick();
            if (s_fire && nreq < 3) begin
                n_checks++;
                if (s_addr !== exp_addr) begin
                    n_fail++;
                    $display("FAIL seq_addr: got %h expected %h", s_addr, exp_addr);
                end
                exp_addr += 32'd4;
                nreq++;
            end
            if (s_out_valid && nout < 3) begin
                n_checks++;
                if (s_out_pc !== exp_pc || s_out_npc !== exp_pc + 32'd4 || s_out_ir !== mem_func(exp_pc)) begin
                    n_fail++;
                    $display("FAIL seq_out: pc=%h npc=%h ir=%h expected %h/%h/%h",
                             s_out_pc, s_out_npc, s_out_ir, exp_pc, exp_pc + 32'd4, mem_func(exp_pc));
                end
                exp_pc += 32'd4;
                nout++;
            end
        end
        n_checks++;
        if (nreq < 3 || nout < 3) begin
            n_fail++;
            $display("FAIL seq_timeout: reqs=%0d outs=%0d expected 3/3", nreq, nout);
        end
    endtask

    task automatic test_stall();
        int  nreq, nout;
        bit  got_fire;
        do_reset();
        deq_ready = 1'b0;
        nreq      = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (s_fire) nreq++;
        end
        n_checks++;
        if (nreq != QDEPTH) begin
            n_fail++;
            $display("FAIL stall_reqs: got %0d requests expected %0d", nreq, QDEPTH);
        end
        n_checks++;
        if (imem_req_valid !== 1'b0 || out_valid !== 1'b1 || out_pc !== RESET_PC) begin
            n_fail++;
            $display("FAIL stall_full: req_valid=%b out_valid=%b out_pc=%h expected 0/1/%h",
                     imem_req_valid, out_valid, out_pc, RESET_PC);
        end
        deq_ready = 1'b1;
        nout      = 0;
        got_fire  = 1'b0;
        for (int c = 0; c < 40 && (nout < QDEPTH || !got_fire); c++) begin
            tick();
            if (s_out_valid && nout < QDEPTH) begin
                n_checks++;
                if (s_out_pc !== RESET_PC + 32'(4 * nout) || s_out_ir !== mem_func(RESET_PC + 32'(4 * nout))) begin
                    n_fail++;
                    $display("FAIL stall_drain: pc=%h ir=%h expected %h/%h", s_out_pc, s_out_ir,
                             RESET_PC + 32'(4 * nout), mem_func(RESET_PC + 32'(4 * nout)));
                end
                nout++;
            end
            if (s_fire && !got_fire) begin
                got_fire = 1'b1;
                n_checks++;
                if (s_addr !== 32'h110) begin
                    n_fail++;
                    $display("FAIL stall_resume: addr=%h expected 00000110", s_addr);
                end
            end
        end
        n_checks++;
        if (nout < QDEPTH || !got_fire) begin
            n_fail++;
            $display("FAIL stall_timeout: outs=%0d fire=%b expected %0d/1", nout, got_fire, QDEPTH);
        end
    endtask

    task automatic test_redirect_wait();
        int nfire;
        bit got_fire, got_out;
        do_reset();
        deq_ready = 1'b0;
        nfire     = 0;
        for (int c = 0; c < 20 && nfire < 3; c++) begin
            tick();
            if (s_fire) nfire++;
            if (nfire == 2) mem_lat = 3;
        end
        n_checks++;
        if (nfire != 3 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rdw_setup: fires=%0d out_valid=%b expected 3/1", nfire, out_valid);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h2002;
        tick();
        redirect_valid = 1'b0;
        deq_ready      = 1'b1;
        mem_lat        = 1;
        n_checks++;
        if (out_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rdw_flush: out_valid=%b req_valid=%b expected 0/0", out_valid, imem_req_valid);
        end
        got_fire = 1'b0;
        got_out  = 1'b0;
        for (int c = 0; c < 30 && !got_out; c++) begin
            tick();
            if (s_fire && !got_fire) begin
                got_fire = 1'b1;
                n_checks++;
                if (s_addr !== 32'h2000) begin
                    n_fail++;
                    $display("FAIL rdw_addr: addr=%h expected 00002000", s_addr);
                end
            end
            if (s_out_valid) begin
                got_out = 1'b1;
                n_checks++;
                if (s_out_pc !== 32'h2000 || s_out_ir !== mem_func(32'h2000)) begin
                    n_fail++;
                    $display("FAIL rdw_out: pc=%h ir=%h expected 00002000/%h", s_out_pc, s_out_ir, mem_func(32'h2000));
                end
            end
        end
        n_checks++;
        if (!got_fire || !got_out) begin
            n_fail++;
            $display("FAIL rdw_timeout: fire=%b out=%b expected 1/1", got_fire, got_out);
        end
    endtask

    task automatic test_redirect_resp();
        bit got_fire, got_out;
        do_reset();
        got_fire = 1'b0;
        for (int c = 0; c < 10 && !got_fire; c++) begin
            tick();
            got_fire = s_fire;
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3000;
        tick();
        redirect_valid = 1'b0;
        n_checks++;
        if (!got_fire || s_resp !== 1'b1) begin
            n_fail++;
            $display("FAIL rdr_setup: fire=%b resp_in_redirect=%b expected 1/1", got_fire, s_resp);
        end
        n_checks++;
        if (imem_req_valid !== 1'b1 || imem_addr !== 32'h3000 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rdr_next_req: req_valid=%b addr=%h out_valid=%b expected 1/00003000/0",
                     imem_req_valid, imem_addr, out_valid);
        end
        got_out = 1'b0;
        for (int c = 0; c < 20 && !got_out; c++) begin
            tick();
            if (s_out_valid) begin
                got_out = 1'b1;
                n_checks++;
                if (s_out_pc !== 32'h3000 || s_out_ir !== mem_func(32'h3000)) begin
                    n_fail++;
                    $display("FAIL rdr_out: pc=%h ir=%h expected 00003000/%h", s_out_pc, s_out_ir, mem_func(32'h3000));
                end
            end
        end
        n_checks++;
        if (!got_out) begin
            n_fail++;
            $display("FAIL rdr_timeout: no output within bound");
        end
    endtask

    task automatic test_req_ready_low();
        do_reset();
        imem_req_ready = 1'b0;
        tick();
        for (int c = 0; c < 5; c++) begin
            tick();
            n_checks++;
            if (s_req_valid !== 1'b1 || s_addr !== RESET_PC || s_out_valid !== 1'b0 || s_resp !== 1'b0) begin
                n_fail++;
                $display("FAIL ready_low: req_valid=%b addr=%h out_valid=%b resp=%b expected 1/%h/0/0",
                         s_req_valid, s_addr, s_out_valid, s_resp, RESET_PC);
            end
        end
        imem_req_ready = 1'b1;
    endtask

    task automatic test_reset_async();
        bit got_fire;
        do_reset();
        deq_ready = 1'b0;
        for (int c = 0; c < 7; c++) tick();
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || imem_req_valid !== 1'b0 || out_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL async_reset: out_valid=%b req_valid=%b out_pc=%h expected 0/0/0",
                     out_valid, imem_req_valid, out_pc);
        end
        mem_pending = 1'b0;
        @(negedge clk);
        rst       = 1'b0;
        deq_ready = 1'b1;
        got_fire  = 1'b0;
        for (int c = 0; c < 5 && !got_fire; c++) begin
            tick();
            if (s_fire) begin
                got_fire = 1'b1;
                n_checks++;
                if (s_addr !== RESET_PC) begin
                    n_fail++;
                    $display("FAIL async_restart: addr=%h expected %h", s_addr, RESET_PC);
                end
            end
        end
        n_checks++;
        if (!got_fire) begin
            n_fail++;
            $display("FAIL async_timeout: no request after reset");
        end
    endtask

`ifdef IF_BYPASS_EN
    task automatic test_bypass();
        bit got_fire;
        do_reset();
        got_fire = 1'b0;
        for (int c = 0; c < 10 && !got_fire; c++) begin
            tick();
            got_fire = s_fire;
        end
        tick();
        n_checks++;
        if (s_resp !== 1'b1 || s_out_valid !== 1'b1 || s_out_pc !== RESET_PC || s_out_ir !== mem_func(RESET_PC)) begin
            n_fail++;
            $display("FAIL bypass_same_cycle: resp=%b out_valid=%b pc=%h ir=%h expected 1/1/%h/%h",
                     s_resp, s_out_valid, s_out_pc, s_out_ir, RESET_PC, mem_func(RESET_PC));
        end
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bypass_not_queued: out_valid=%b expected 0", out_valid);
        end
    endtask
`endif

    task automatic test_random();
        logic [63:0] q[$];
        logic [63:0] front;
        logic [31:0] exp_fetch, e_pc, e_ir;
        bit outstanding, stale, idle, byp, exp_ov, exp_rv;
        do_reset();
        exp_fetch   = RESET_PC;
        outstanding = 1'b0;
        stale       = 1'b0;
        idle        = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            deq_ready      = ($urandom_range(0, 3) != 0);
            imem_req_ready = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 31) == 0);
            redirect_pc    = $urandom;
            mem_lat        = $urandom_range(1, 3);
            tick();
            byp    = BYP && (q.size() == 0) && s_resp && outstanding && !stale && !s_redirect;
            exp_ov = (q.size() != 0) || byp;
            exp_rv = !idle && !outstanding && (q.size() < QDEPTH);
            n_checks++;
            if (s_out_valid !== exp_ov || s_req_valid !== exp_rv) begin
                n_fail++;
                $display("FAIL rand_valids cycle %0d: out_valid=%b req_valid=%b expected %b/%b",
                         c, s_out_valid, s_req_valid, exp_ov, exp_rv);
            end
            if (s_fire) begin
                n_checks++;
                if (s_addr !== exp_fetch) begin
                    n_fail++;
                    $display("FAIL rand_addr cycle %0d: addr=%h expected %h", c, s_addr, exp_fetch);
                end
            end
            if (s_out_valid && s_deq_ready && !s_redirect) begin
                if (q.size() != 0) begin
                    front = q.pop_front();
                    e_pc  = front[63:32];
                    e_ir  = front[31:0];
                end else begin
                    e_pc = exp_fetch;
                    e_ir = mem_func(exp_fetch);
                end
                n_checks++;
                if (s_out_pc !== e_pc || s_out_ir !== e_ir || s_out_npc !== e_pc + 32'd4) begin
                    n_fail++;
                    $display("FAIL rand_out cycle %0d: pc=%h npc=%h ir=%h expected %h/%h/%h",
                             c, s_out_pc, s_out_npc, s_out_ir, e_pc, e_pc + 32'd4, e_ir);
                end
            end
            if (s_redirect) begin
                q.delete();
                exp_fetch = {s_rpc[31:2], 2'b00};
                if (outstanding && !s_resp) begin
                    stale = 1'b1;
                end else begin
                    outstanding = 1'b0;
                    stale       = 1'b0;
                end
                if (s_fire) begin
                    outstanding = 1'b1;
                    stale       = 1'b1;
                end
            end else begin
                if (s_resp) begin
                    if (!stale) begin
                        if (!(byp && s_deq_ready)) q.push_back({exp_fetch, mem_func(exp_fetch)});
                        exp_fetch += 32'd4;
                    end
                    outstanding = 1'b0;
                    stale       = 1'b0;
                end
                if (s_fire) begin
                    outstanding = 1'b1;
                    stale       = 1'b0;
                end
            end
            idle = 1'b0;
        end
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_wait();
        test_redirect_resp();
        test_req_ready_low();
        test_reset_async();
`ifdef IF_BYPASS_EN
        test_bypass();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
